// File: rtl/gamepad_reader.sv
// Serial gamepad initiator: latches two pads sharing pad_latch/pad_clk and shifts in
// BUTTON_COUNT bits from each. A poll's result is published all at once on its last sample edge.
module gamepad_reader #(
   parameter int HALF_PERIOD  = 8,
   parameter int BUTTON_COUNT = 12,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [1:0]              pad_data,
   output logic                    pad_latch,
   output logic                    pad_clk,
   output logic [BUTTON_COUNT-1:0] p1_buttons,
   output logic [BUTTON_COUNT-1:0] p2_buttons,
   output logic                    valid,
   output logic                    busy
);

   localparam int PW = (HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
   localparam int BW = $clog2(BUTTON_COUNT);

   localparam logic [PW-1:0] LATCH_LOAD = PW'(2 * HALF_PERIOD - 1);
   localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_PERIOD - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(BUTTON_COUNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SETTLE,
      CLK_HIGH,
      CLK_LOW
   } state_t;

   state_t                  state;
   logic [PW-1:0]           phase_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [BUTTON_COUNT-1:0] p1_shift;
   logic [BUTTON_COUNT-1:0] p2_shift;
   logic [1:0]              sample_bits;

   // Polarity is fixed at elaboration, so inversion is a constant XOR on the inputs.
   assign sample_bits = pad_data ^ {2{ACTIVE_LOW}};

   // NOTE: every register here, including the shift registers, is cleared by reset so an
   // aborted poll leaves no partial word that could later leak into the outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         bit_cnt    <= '0;
         p1_shift   <= '0;
         p2_shift   <= '0;
         p1_buttons <= '0;
         p2_buttons <= '0;
         pad_latch  <= 1'b0;
         pad_clk    <= 1'b0;
         valid      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge values of the registers it updates.
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LATCH;
                  pad_latch <= 1'b1;
                  busy      <= 1'b1;
                  phase_cnt <= LATCH_LOAD;
               end
            end

            LATCH: begin
               if (phase_cnt == '0) begin
                  pad_latch <= 1'b0;
                  state     <= SETTLE;
                  phase_cnt <= HALF_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - PW'(1);
               end
            end

            SETTLE: begin
               if (phase_cnt == '0) begin
                  // Bit 0 is presented by the pads as soon as they are latched.
                  p1_shift  <= {sample_bits[0], p1_shift[BUTTON_COUNT-1:1]};
                  p2_shift  <= {sample_bits[1], p2_shift[BUTTON_COUNT-1:1]};
                  bit_cnt   <= BW'(1);
                  pad_clk   <= 1'b1;
                  state     <= CLK_HIGH;
                  phase_cnt <= HALF_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - PW'(1);
               end
            end

            CLK_HIGH: begin
               if (phase_cnt == '0) begin
                  pad_clk   <= 1'b0;
                  state     <= CLK_LOW;
                  phase_cnt <= HALF_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - PW'(1);
               end
            end

            CLK_LOW: begin
               if (phase_cnt == '0) begin
                  p1_shift <= {sample_bits[0], p1_shift[BUTTON_COUNT-1:1]};
                  p2_shift <= {sample_bits[1], p2_shift[BUTTON_COUNT-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     // Publish includes the bit sampled on this very edge.
                     p1_buttons <= {sample_bits[0], p1_shift[BUTTON_COUNT-1:1]};
                     p2_buttons <= {sample_bits[1], p2_shift[BUTTON_COUNT-1:1]};
                     valid      <= 1'b1;
                     busy       <= 1'b0;
                     bit_cnt    <= '0;
                     state      <= IDLE;
                  end else begin
                     bit_cnt   <= bit_cnt + BW'(1);
                     pad_clk   <= 1'b1;
                     state     <= CLK_HIGH;
                     phase_cnt <= HALF_LOAD;
                  end
               end else begin
                  phase_cnt <= phase_cnt - PW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench: three gamepad_reader instances (default, ACTIVE_LOW, H=1/N=2), each driven
// by a behavioural pad responder and watched by pin-activity monitors.
module tb_gamepad_reader;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A: defaults ----------------
   logic        start_a = 1'b0;
   logic [1:0]  data_a;
   logic        latch_a, pclk_a, valid_a, busy_a;
   logic [11:0] p1_a, p2_a, p1w_a, p2w_a;
   int          idx_a = 0;

   gamepad_reader dut_a (
      .clk(clk), .reset(reset), .start(start_a), .pad_data(data_a),
      .pad_latch(latch_a), .pad_clk(pclk_a), .p1_buttons(p1_a), .p2_buttons(p2_a),
      .valid(valid_a), .busy(busy_a)
   );

   always @(posedge latch_a) idx_a = 0;
   always @(posedge pclk_a) idx_a = idx_a + 1;
   assign data_a = (idx_a < 12) ? {p2w_a[idx_a], p1w_a[idx_a]} : 2'b00;

   // ---------------- instance B: ACTIVE_LOW ----------------
   logic        start_b = 1'b0;
   logic [1:0]  data_b;
   logic        latch_b, pclk_b, valid_b, busy_b;
   logic [11:0] p1_b, p2_b, p1w_b, p2w_b;
   int          idx_b = 0;
   int          vcnt_b = 0;

   gamepad_reader #(.HALF_PERIOD(8), .BUTTON_COUNT(12), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .pad_data(data_b),
      .pad_latch(latch_b), .pad_clk(pclk_b), .p1_buttons(p1_b), .p2_buttons(p2_b),
      .valid(valid_b), .busy(busy_b)
   );

   always @(posedge latch_b) idx_b = 0;
   always @(posedge pclk_b) idx_b = idx_b + 1;
   assign data_b = (idx_b < 12) ? {p2w_b[idx_b], p1w_b[idx_b]} : 2'b11;
   always @(negedge clk) if (valid_b) vcnt_b = vcnt_b + 1;

   // ---------------- instance C: H=1, N=2 ----------------
   logic       start_c = 1'b0;
   logic [1:0] data_c;
   logic       latch_c, pclk_c, valid_c, busy_c;
   logic [1:0] p1_c, p2_c, p1w_c, p2w_c;
   int         idx_c = 0;

   gamepad_reader #(.HALF_PERIOD(1), .BUTTON_COUNT(2), .ACTIVE_LOW(1'b0)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .pad_data(data_c),
      .pad_latch(latch_c), .pad_clk(pclk_c), .p1_buttons(p1_c), .p2_buttons(p2_c),
      .valid(valid_c), .busy(busy_c)
   );

   always @(posedge latch_c) idx_c = 0;
   always @(posedge pclk_c) idx_c = idx_c + 1;
   assign data_c = (idx_c < 2) ? {p2w_c[idx_c], p1w_c[idx_c]} : 2'b00;

   // ---------------- pin monitors, sampled on the falling edge ----------------
   typedef struct {
      int latch_hi, latch_rises, clk_rises, wmin, wmax, width, vcnt, vcyc;
      bit prev_latch, prev_clk;
   } mon_t;

   mon_t mon_a, mon_c;

   function automatic mon_t mon_clear();
      mon_t m;
      m.latch_hi = 0; m.latch_rises = 0; m.clk_rises = 0;
      m.wmin = 1000; m.wmax = 0; m.width = 0; m.vcnt = 0; m.vcyc = -1;
      m.prev_latch = 1'b0; m.prev_clk = 1'b0;
      return m;
   endfunction

   function automatic mon_t mon_step(mon_t m, logic lat, logic pc, logic v, int c);
      if (lat) m.latch_hi++;
      if (lat && !m.prev_latch) m.latch_rises++;
      if (pc) begin
         if (!m.prev_clk) m.clk_rises++;
         m.width++;
      end else if (m.prev_clk) begin
         if (m.width < m.wmin) m.wmin = m.width;
         if (m.width > m.wmax) m.wmax = m.width;
         m.width = 0;
      end
      if (v) begin
         m.vcnt++;
         m.vcyc = c;
      end
      m.prev_latch = lat;
      m.prev_clk   = pc;
      return m;
   endfunction

   always @(negedge clk) begin
      mon_a = mon_step(mon_a, latch_a, pclk_a, valid_a, cyc);
      mon_c = mon_step(mon_c, latch_c, pclk_c, valid_c, cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mons();
      @(posedge clk);
      mon_a = mon_clear();
      mon_c = mon_clear();
      vcnt_b = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse start for one edge; returns cyc as seen just after the accepting edge E0.
   task automatic pulse_a(output int e0);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); e0 = cyc; start_a = 1'b0;
   endtask

   int e0;

   initial begin
      mon_a = mon_clear();
      mon_c = mon_clear();
      p1w_a = 12'h000; p2w_a = 12'h000;
      p1w_b = 12'hFFF; p2w_b = 12'hFFF;
      p1w_c = 2'b00;   p2w_c = 2'b00;

      // Reset and idle
      reset = 1'b1;
      #1;
      check("rst_latch", 32'(latch_a), 32'd0);
      check("rst_busy_valid", {30'd0, busy_a, valid_a}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_mons();
      idle(50);
      check("idle_latch_rises", mon_a.latch_rises, 0);
      check("idle_clk_rises", mon_a.clk_rises, 0);
      check("idle_valid", mon_a.vcnt, 0);
      check("idle_buttons", {8'd0, p1_a, p2_a}, 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);

      // Default poll: P1=A5C, P2=3F1
      p1w_a = 12'hA5C; p2w_a = 12'h3F1;
      clear_mons();
      pulse_a(e0);
      check("a_busy_at_e0", 32'(busy_a), 32'd1);
      idle(260);
      check("a_latch_hi", mon_a.latch_hi, 16);
      check("a_latch_rises", mon_a.latch_rises, 1);
      check("a_clk_pulses", mon_a.clk_rises, 11);
      check("a_clk_wmin", mon_a.wmin, 8);
      check("a_clk_wmax", mon_a.wmax, 8);
      check("a_valid_cnt", mon_a.vcnt, 1);
      check("a_valid_time", mon_a.vcyc - e0, 200);
      check("a_p1", 32'(p1_a), 32'hA5C);
      check("a_p2", 32'(p2_a), 32'h3F1);
      check("a_busy_after", 32'(busy_a), 32'd0);
      check("a_clk_idle", 32'(pclk_a), 32'd0);

      // Held outputs do not follow pad activity between polls
      p1w_a = 12'h001; p2w_a = 12'hFFE;
      idle(40);
      check("hold_p1", 32'(p1_a), 32'hA5C);
      check("hold_p2", 32'(p2_a), 32'h3F1);

      // Second start during a poll is ignored
      clear_mons();
      pulse_a(e0);
      idle(48);
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      idle(260);
      check("re_latch_rises", mon_a.latch_rises, 1);
      check("re_valid_cnt", mon_a.vcnt, 1);
      check("re_valid_time", mon_a.vcyc - e0, 200);
      check("re_p1", 32'(p1_a), 32'h001);
      check("re_p2", 32'(p2_a), 32'hFFE);

      // Reset mid-poll aborts with no publish
      p1w_a = 12'h5A5; p2w_a = 12'h0F0;
      clear_mons();
      pulse_a(e0);
      idle(99);
      check("mid_busy_before", 32'(busy_a), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_latch_clk", {30'd0, latch_a, pclk_a}, 32'd0);
      check("mid_busy", 32'(busy_a), 32'd0);
      check("mid_buttons", {8'd0, p1_a, p2_a}, 32'd0);
      @(negedge clk); reset = 1'b0;
      clear_mons();
      idle(250);
      check("mid_no_valid", mon_a.vcnt, 0);
      check("mid_held_zero", {8'd0, p1_a, p2_a}, 32'd0);
      clear_mons();
      pulse_a(e0);
      idle(260);
      check("post_valid_time", mon_a.vcyc - e0, 200);
      check("post_p1", 32'(p1_a), 32'h5A5);
      check("post_p2", 32'(p2_a), 32'h0F0);

      // ACTIVE_LOW: P1 bit 0 low (pressed), everything else high
      p1w_b = 12'hFFE; p2w_b = 12'hFFF;
      clear_mons();
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      idle(260);
      check("b_valid_cnt", vcnt_b, 1);
      check("b_p1", 32'(p1_b), 32'h001);
      check("b_p2", 32'(p2_b), 32'h000);

      // Minimum geometry H=1, N=2
      p1w_c = 2'b10; p2w_c = 2'b01;
      clear_mons();
      @(negedge clk); start_c = 1'b1;
      @(negedge clk); e0 = cyc; start_c = 1'b0;
      idle(20);
      check("c_latch_hi", mon_c.latch_hi, 2);
      check("c_clk_pulses", mon_c.clk_rises, 1);
      check("c_clk_width", mon_c.wmax, 1);
      check("c_valid_cnt", mon_c.vcnt, 1);
      check("c_valid_time", mon_c.vcyc - e0, 5);
      check("c_p1", 32'(p1_c), 32'h2);
      check("c_p2", 32'(p2_c), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
